dmem_mmio: RTL
==============

// Module: dmem_mmio
// PURPOSE
//  Parametrised data memory for the single-cycle RISC-V core: byte/half/word loads and stores selected by funct3,
//  misalignment detection, a memory-mapped TOHOST halt/exit register and a store-log FIFO drained by a valid/ready
//  handshake. Sits on the core's alu_result/write_data/mem_write/read_data path; replaces the plain dmem in the bench.
// PARAMETERS
//  DEPTH_WORDS  1024           RAM size in 32-bit words; power of two; RAM occupies [0, DEPTH_WORDS*4)
//  MMIO_BASE    32'h8000_0000  base of MMIO window; TOHOST at MMIO_BASE+0 (word only)
//  LOG_DEPTH    8              store-log FIFO entries; power of two, >=2
//  INIT_FILE    ""             $readmemh image loaded at time 0 when non-empty
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  reset         in   1   synchronous, active-low (0 = reset)
//  we            in   1   store request this cycle
//  addr          in   32  byte address
//  wd            in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  funct3        in   3   access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  rd            out  32  load data, sign/zero-extended; combinational
//  misaligned    out  1   combinational: H/HU with addr[0]=1, or W with addr[1:0]!=0
//  halted        out  1   TOHOST halt latched
//  exit_code     out  31  TOHOST wd[31:1] captured at halt
//  log_valid     out  1   log FIFO non-empty
//  log_ready     in   1   consumer pops head when log_valid && log_ready
//  log_addr      out  32  head entry: byte address of store
//  log_data      out  32  head entry: wd masked to access size (upper bits zero for B/H)
//  log_drop_cnt  out  16  stores lost to full FIFO; saturates at 16'hFFFF
//  store_cnt     out  32  accepted stores; wraps
// BEHAVIOUR
//  - Reset (reset=0 at edge): halted=0, exit_code=0, FIFO empty (log_valid=0, log_addr/log_data=0), log_drop_cnt=0,
//    store_cnt=0. RAM contents NOT cleared. Reset wins over any simultaneous store/pop.
//  - Loads: zero latency. RAM hit -> lane select by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unmodified.
//    TOHOST read -> {exit_code, halted}. Misaligned or unmapped address -> rd=0.
//  - Accepted store = we && reset && !misaligned && !halted && address mapped (RAM, or TOHOST with funct3=W).
//    Non-accepted stores: no RAM, register, counter or log effect.
//  - RAM store: writes only addressed byte lanes on rising edge; new data visible on rd next cycle.
//  - TOHOST store: if wd[0]=1 -> halted<=1, exit_code<=wd[31:1]; wd[0]=0 -> no state change but still logged/counted.
//    Once halted, all later stores ignored until reset; loads continue to work.
//  - Log FIFO: first-word fall-through; each accepted store pushes {addr, masked wd} same edge.
//    Push+pop same cycle: both occur, occupancy unchanged, legal also when full or when empty-with-push (no bypass:
//    empty FIFO shows new entry on log_valid next cycle). Full, push, no pop -> entry dropped, log_drop_cnt++ (sat).
//    Pop when empty ignored. Pointers wrap mod LOG_DEPTH; full/empty via extra pointer bit.
//  - store_cnt increments on every accepted store including dropped log entries; wraps 0xFFFF_FFFF -> 0.
// STRUCTURE
//  - riscv_pkg: localparams F3_B/F3_H/F3_W/F3_BU/F3_HU, TOHOST_OFS; shared with core decoder.
//  - Sub-module sync_fifo #(WIDTH=64, DEPTH=LOG_DEPTH): push/pop/full/empty/head; FWFT, same-cycle push+pop.
//  - Top: RAM array, load-extend mux, misalign/decode logic, TOHOST regs, counters.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then LB/LBU/LH/LHU @0x13,0x12 -> rd=FFFFFFDE,000000DE,FFFFDEAD,0000DEAD.
//  2 SB 0x5A @0x11 over (1) -> LW @0x10 = DEAD5AEF; log head {0x11, 0x0000005A}; store_cnt=2.
//  3 SH @0x11, SW @0x12 -> misaligned=1, memory unchanged, store_cnt and log unchanged.
//  4 log_ready=0, LOG_DEPTH+3 stores -> log_valid=1, log_drop_cnt=3; one push+pop cycle while full -> occupancy stays
//    LOG_DEPTH, drop_cnt stays 3; drain yields oldest-first order.
//  5 SW 0x0000_0007 @MMIO_BASE -> halted=1, exit_code=3, LW @MMIO_BASE=7; subsequent SW @0x20 ignored.
//  6 reset=0 for one cycle mid-run with push+pop pending -> all outputs at reset values next cycle; RAM @0x10 retained.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: load/store funct3 encodings and the TOHOST offset
// inside the MMIO window.
package riscv_pkg;

   localparam logic [2:0]  F3_B       = 3'b000;
   localparam logic [2:0]  F3_H       = 3'b001;
   localparam logic [2:0]  F3_W       = 3'b010;
   localparam logic [2:0]  F3_BU      = 3'b100;
   localparam logic [2:0]  F3_HU      = 3'b101;
   localparam logic [31:0] TOHOST_OFS = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO. Same-cycle push and pop are both honoured,
// including when the FIFO is full. There is no bypass, so a push into an empty
// FIFO becomes visible on the next cycle. Full and empty come from an extra
// wrap bit carried on each pointer.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; reset takes priority over any push or pop in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write. When the FIFO is full and a pop happens in the same cycle,
   // the slot being written is the one being vacated.
   always_ff @(posedge clk) begin
      if (do_push && reset) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core. Provides byte, half and word loads and
// stores, misalignment detection, a TOHOST halt/exit register, and a log of
// accepted stores that a consumer drains through a valid/ready handshake.
module dmem_mmio
   import riscv_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
   parameter int          LOG_DEPTH   = 8,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic [2:0]  funct3,
   output logic [31:0] rd,
   output logic        misaligned,
   output logic        halted,
   output logic [30:0] exit_code,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic [15:0] log_drop_cnt,
   output logic [31:0] store_cnt
);

   localparam int RAM_AW = $clog2(DEPTH_WORDS);

   logic [31:0]       ram [DEPTH_WORDS];
   logic [RAM_AW-1:0] word_idx;
   logic [31:0]       ram_word;
   logic              is_b, is_h, is_w;
   logic              ram_ok, tohost_ok, accept;
   logic [3:0]        be;
   logic [31:0]       wdata, log_wd;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic              fifo_full, fifo_empty;
   logic [63:0]       fifo_head;

   assign word_idx = addr[RAM_AW+1:2];
   assign ram_word = ram[word_idx];

   // Access-size decode, misalignment and address mapping; unknown funct3 maps nothing.
   always_comb begin
      is_b       = (funct3 == F3_B) || (funct3 == F3_BU);
      is_h       = (funct3 == F3_H) || (funct3 == F3_HU);
      is_w       = (funct3 == F3_W);
      misaligned = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
      ram_ok     = (addr[31:RAM_AW+2] == '0) && (is_b || is_h || is_w);
      tohost_ok  = (addr == MMIO_BASE + TOHOST_OFS) && is_w;
      accept     = we && reset && !misaligned && !halted && (ram_ok || tohost_ok);
   end

   // Byte-lane enables, lane-replicated RAM write data and size-masked log data.
   always_comb begin
      be     = 4'b0000;
      wdata  = '0;
      log_wd = '0;
      if (is_b) begin
         be     = 4'b0001 << addr[1:0];
         wdata  = {4{wd[7:0]}};
         log_wd = {24'h0, wd[7:0]};
      end else if (is_h) begin
         be     = addr[1] ? 4'b1100 : 4'b0011;
         wdata  = {2{wd[15:0]}};
         log_wd = {16'h0, wd[15:0]};
      end else if (is_w) begin
         be     = 4'b1111;
         wdata  = wd;
         log_wd = wd;
      end
   end

   // RAM byte-lane write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (accept && ram_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Lane select followed by sign or zero extension; TOHOST reads back the halt state.
   always_comb begin
      case (addr[1:0])
         2'd0:    lane_b = ram_word[7:0];
         2'd1:    lane_b = ram_word[15:8];
         2'd2:    lane_b = ram_word[23:16];
         default: lane_b = ram_word[31:24];
      endcase
      lane_h = addr[1] ? ram_word[31:16] : ram_word[15:0];
      rd     = '0;
      if (!misaligned) begin
         if (ram_ok) begin
            case (funct3)
               F3_B:    rd = {{24{lane_b[7]}}, lane_b};
               F3_BU:   rd = {24'h0, lane_b};
               F3_H:    rd = {{16{lane_h[15]}}, lane_h};
               F3_HU:   rd = {16'h0, lane_h};
               default: rd = ram_word;
            endcase
         end else if (tohost_ok) begin
            rd = {exit_code, halted};
         end
      end
   end

   // TOHOST halt latch and the store / drop counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         halted       <= 1'b0;
         exit_code    <= '0;
         log_drop_cnt <= '0;
         store_cnt    <= '0;
      end else if (accept) begin
         store_cnt <= store_cnt + 32'd1;
         if (tohost_ok && wd[0]) begin
            halted    <= 1'b1;
            exit_code <= wd[31:1];
         end
         if (fifo_full && !log_ready && (log_drop_cnt != 16'hFFFF))
            log_drop_cnt <= log_drop_cnt + 16'd1;
      end
   end

   sync_fifo #(.WIDTH(64), .DEPTH(LOG_DEPTH)) u_log (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data ({addr, log_wd}),
      .pop       (log_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign log_valid = !fifo_empty;
   assign log_addr  = fifo_head[63:32];
   assign log_data  = fifo_head[31:0];

endmodule
